// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port synchronous RAM between NUM_REQ requesters. Requests are
// picked round-robin, and only one transaction is in flight at a time.
// The RAM has a registered read: read data comes back one cycle after the address
// is sampled.
//
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   req_valid     per-requester request present
//   req_ready     per-requester accept strobe (combinational, IDLE only)
//   req_we        per-requester 1=write, 0=read
//   req_addr      packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata     packed write data, same packing
//   rsp_valid     one-cycle completion pulse to the granted requester
//   rsp_rdata     read data, valid with rsp_valid for reads
//   busy          high whenever the FSM is not idle
//   ram_wr_en     RAM write enable
//   ram_addr      RAM address
//   ram_wr_data   RAM write data
//   ram_rd_data   RAM registered read data
module ram_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned NUM_REQ    = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             busy,
   output logic                             ram_wr_en,
   output logic [ADDR_WIDTH-1:0]            ram_addr,
   output logic [DATA_WIDTH-1:0]            ram_wr_data,
   input  logic [DATA_WIDTH-1:0]            ram_rd_data
);

   localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                 state, state_d;
   logic [GW-1:0]          last_grant, last_grant_d;
   logic [GW-1:0]          gnt, gnt_d;
   logic                   op_we, op_we_d;
   logic                   ram_wr_en_d;
   logic [ADDR_WIDTH-1:0]  ram_addr_d;
   logic [DATA_WIDTH-1:0]  ram_wr_data_d;
   logic [NUM_REQ-1:0]     rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_rdata_d;
   logic                   busy_d;

   logic                   arb_found;
   logic [GW-1:0]          arb_pick;
   logic [GW-1:0]          cand;

   logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

   // Unpack per-requester address and write data.
   for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // k-th candidate in round-robin order, starting just after the last grant.
   function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned k);
      int unsigned s;
      s = (32'(base) + k + 32'd1) % NUM_REQ;
      return GW'(s);
   endfunction

   // Round-robin search: first valid requester after last_grant, with wrap-around.
   always_comb begin
      arb_found = 1'b0;
      arb_pick  = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = rr_idx(last_grant, k);
         if (!arb_found && req_valid[cand]) begin
            arb_found = 1'b1;
            arb_pick  = cand;
         end
      end
   end

   // Ready only in IDLE and never while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && !rst && arb_found) begin
         req_ready[arb_pick] = 1'b1;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state;
      last_grant_d  = last_grant;
      gnt_d         = gnt;
      op_we_d       = op_we;
      ram_wr_en_d   = 1'b0;
      ram_addr_d    = ram_addr;
      ram_wr_data_d = ram_wr_data;
      rsp_valid_d   = '0;
      rsp_rdata_d   = rsp_rdata;

      case (state)
         IDLE: begin
            if (arb_found) begin
               gnt_d         = arb_pick;
               last_grant_d  = arb_pick;
               op_we_d       = req_we[arb_pick];
               ram_wr_en_d   = req_we[arb_pick];
               ram_addr_d    = addr_arr[arb_pick];
               ram_wr_data_d = wdata_arr[arb_pick];
               state_d       = ACCESS;
            end
         end
         ACCESS: begin
            // RAM samples addr/wr_en at the end of this cycle.
            if (op_we) begin
               rsp_valid_d[gnt] = 1'b1;
               state_d          = RESP;
            end else begin
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            rsp_rdata_d      = ram_rd_data;
            rsp_valid_d[gnt] = 1'b1;
            state_d          = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= GW'(NUM_REQ - 1);
         gnt         <= '0;
         op_we       <= 1'b0;
         ram_wr_en   <= 1'b0;
         ram_addr    <= '0;
         ram_wr_data <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         last_grant  <= last_grant_d;
         gnt         <= gnt_d;
         op_we       <= op_we_d;
         ram_wr_en   <= ram_wr_en_d;
         ram_addr    <= ram_addr_d;
         ram_wr_data <= ram_wr_data_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural registered-read RAM.
module tb_ram_port_arbiter;

   localparam int unsigned DW = 4;
   localparam int unsigned AW = 2;
   localparam int unsigned NR = 2;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_we;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              busy;
   logic              ram_wr_en;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_wr_data;
   logic [DW-1:0]     ram_rd_data;

   logic [DW-1:0]     mem [4];
   logic [DW-1:0]     last_rd;

   int n_tests = 0;
   int n_fail  = 0;

   ram_port_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REQ    (NR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .busy        (busy),
      .ram_wr_en   (ram_wr_en),
      .ram_addr    (ram_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_data (ram_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM, registered read (old data on read-during-write).
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_addr];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from requester g in the current IDLE cycle and check its
   // full cycle-by-cycle timing; returns in the IDLE cycle after the response.
   task automatic issue(input int g, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input bit keep);
      logic [NR-1:0] oh;
      oh = '0;
      oh[g] = 1'b1;
      req_valid[g] = 1'b1;
      req_we[g]    = we;
      req_addr[g*AW +: AW]  = a;
      req_wdata[g*DW +: DW] = wd;
      #1;
      check("ready_T", 32'(req_ready), 32'(oh));
      check("busy_T", 32'(busy), 32'd0);
      tick();
      if (!keep) req_valid[g] = 1'b0;
      #1;
      check("ready_T1", 32'(req_ready), 32'd0);
      check("wr_en_T1", 32'(ram_wr_en), 32'(we));
      check("addr_T1", 32'(ram_addr), 32'(a));
      if (we) check("wdata_T1", 32'(ram_wr_data), 32'(wd));
      check("busy_T1", 32'(busy), 32'd1);
      check("rsp_T1", 32'(rsp_valid), 32'd0);
      tick();
      check("wr_en_T2", 32'(ram_wr_en), 32'd0);
      check("addr_T2", 32'(ram_addr), 32'(a));
      check("busy_T2", 32'(busy), 32'd1);
      if (we) begin
         check("rsp_wr_T2", 32'(rsp_valid), 32'(oh));
         check("rdata_hold", 32'(rsp_rdata), 32'(last_rd));
      end else begin
         check("rsp_rd_T2", 32'(rsp_valid), 32'd0);
         tick();
         check("rsp_rd_T3", 32'(rsp_valid), 32'(oh));
         check("rdata_T3", 32'(rsp_rdata), 32'(exp_rd));
         check("busy_T3", 32'(busy), 32'd1);
         check("wr_en_T3", 32'(ram_wr_en), 32'd0);
         last_rd = exp_rd;
      end
      tick();
      check("rsp_off", 32'(rsp_valid), 32'd0);
      check("busy_off", 32'(busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      last_rd   = '0;
      for (int i = 0; i < 4; i++) mem[i] = DW'(i + 4);

      // Reset state; valid during reset must not be readied.
      tick();
      tick();
      req_valid = 2'b01;
      #1;
      check("ready_in_rst", 32'(req_ready), 32'd0);
      check("busy_rst", 32'(busy), 32'd0);
      check("wr_en_rst", 32'(ram_wr_en), 32'd0);
      check("addr_rst", 32'(ram_addr), 32'd0);
      check("wdata_rst", 32'(ram_wr_data), 32'd0);
      check("rsp_rst", 32'(rsp_valid), 32'd0);
      check("rdata_rst", 32'(rsp_rdata), 32'd0);
      tick();
      rst = 1'b0;

      // Write then read back by requester 0.
      issue(0, 1'b1, 2'd2, 4'hA, 4'h0, 1'b0);
      issue(0, 1'b0, 2'd2, 4'h0, 4'hA, 1'b0);
      check("mem2", 32'(mem[2]), 32'hA);

      // Both requesters continuously valid: fresh reset so requester 0 wins first.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_rd = '0;
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = {2'd3, 2'd1};
      for (int r = 0; r < 2; r++) begin
         issue(0, 1'b0, 2'd1, 4'h0, 4'h5, 1'b1);
         issue(1, 1'b0, 2'd3, 4'h0, 4'h7, 1'b1);
      end
      req_valid = '0;

      // Lone requester 1: back-to-back writes, then read-back.
      for (int k = 0; k < 3; k++) issue(1, 1'b1, AW'(k), DW'(k + 1), 4'h0, 1'b1);
      for (int k = 0; k < 3; k++) issue(1, 1'b0, AW'(k), 4'h0, DW'(k + 1), 1'b1);
      req_valid = '0;

      // Reset during the ACCESS cycle of a read by requester 0.
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[AW-1:0] = 2'd1;
      #1;
      check("ready_pre_rst", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b10;
      req_we    = 2'b00;
      req_addr[2*AW-1:AW] = 2'd3;
      rst = 1'b1;
      #1;
      check("ready_during_rst", 32'(req_ready), 32'd0);
      check("busy_access", 32'(busy), 32'd1);
      tick();
      rst = 1'b0;
      last_rd = '0;
      check("busy_after_rst", 32'(busy), 32'd0);
      check("rsp_after_rst", 32'(rsp_valid), 32'd0);
      check("addr_after_rst", 32'(ram_addr), 32'd0);
      check("rdata_after_rst", 32'(rsp_rdata), 32'd0);
      issue(1, 1'b0, 2'd3, 4'h0, 4'h7, 1'b0);

      // Simultaneous write (req1) and read (req0) of addr 3; last grant was 1,
      // so the read goes first and sees the old data.
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[2*AW-1:AW]  = 2'd3;
      req_wdata[2*DW-1:DW] = 4'h5;
      issue(0, 1'b0, 2'd3, 4'h0, 4'h7, 1'b0);
      issue(1, 1'b1, 2'd3, 4'h5, 4'h0, 1'b0);
      issue(0, 1'b0, 2'd3, 4'h0, 4'h5, 1'b0);

      // Same race on addr 2 with last grant 0: the write goes first.
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[AW-1:0] = 2'd2;
      issue(1, 1'b1, 2'd2, 4'h9, 4'h0, 1'b0);
      issue(0, 1'b0, 2'd2, 4'h0, 4'h9, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (registered read, one-cycle read latency, write on clock edge when write-enable is high) between NUM_REQ requesters.
- Each requester has a valid/ready request channel and a one-cycle response pulse.
- Round-robin arbitration; one transaction in flight at a time.
- Sits between client logic and the RAM macro; drives the RAM's write-enable, address and write-data pins and samples its read-data pin.

Parameters:
- DATA_WIDTH, 4, RAM word width.
- ADDR_WIDTH, 2, RAM address width.
- NUM_REQ, 2, number of requesters (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (combinational).
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid when rsp_valid is set for a read.
- busy  out  1  high when state != IDLE.
- ram_wr_en  out  1  to RAM write enable.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_wr_data  out  DATA_WIDTH  to RAM write data.
- ram_rd_data  in  DATA_WIDTH  from RAM registered read data.

Behaviour:
- Interface: one clock `clk`; synchronous, active-high reset `rst`.
- Reset values: state=IDLE; ram_wr_en=0; ram_addr=0; ram_wr_data=0; rsp_valid=0; rsp_rdata=0; busy=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE arbitration:
  - Search starts at (last_grant+1) mod NUM_REQ, wraps, picks the first i with req_valid[i]=1.
  - req_ready[i]=1 only for that i, only in IDLE.
  - All req_ready are 0 in every other state and when no valid is present.
- Accept (valid&ready, cycle T), at the edge:
  - latch gnt=i and we/addr/wdata of i into ram_addr, ram_wr_data and an op register;
  - ram_wr_en <= req_we[i];
  - last_grant <= i;
  - state -> ACCESS.
- ACCESS (T+1):
  - RAM samples addr/wr_en at the end of this cycle.
  - Next edge clears ram_wr_en.
  - Write goes to RESP; read goes to RDWAIT.
- RDWAIT (read, T+2):
  - ram_rd_data now valid.
  - rsp_rdata <= ram_rd_data; state -> RESP.
  - ram_addr is held unchanged through ACCESS and RDWAIT.
- RESP:
  - rsp_valid[gnt]=1 for exactly this cycle; state -> IDLE.
  - Write: response in T+2, rsp_rdata keeps its previous value.
  - Read: response in T+3.
- Throughput: new requests accepted only in IDLE. Minimum spacing between accepts is 3 cycles for a write and 4 for a read.
- ram_wr_en is high for exactly one cycle per write and never high for reads.
- ram_addr and ram_wr_data hold their last values when idle.
- Requester protocol:
  - Requester holds valid/we/addr/wdata stable until ready.
  - Dropping valid before ready is a protocol violation and is not checked.
  - A requester may re-assert valid in the same cycle its rsp_valid is high; it is accepted no earlier than the following IDLE cycle.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
  - A lone requester is granted back-to-back.
- Ordering: transactions are strictly serialized, so a read issued after a write to the same address returns the new data.
- Reset mid-operation: rst in any state forces the reset values at that edge. The in-flight transaction is dropped: no rsp_valid, and ram_wr_en is low from the next cycle. A write already sampled by the RAM stays in the RAM.
- rst overrides a simultaneous accept: req_ready=0 while rst=1.

Test Plan:
- Reset then write from req0 (addr=2, wdata=0xA): ready0 in T; ram_wr_en=1, ram_addr=2, ram_wr_data=0xA in T+1 only; rsp_valid[0] in T+2.
- Read req0 addr=2 after that write: ram_wr_en stays 0; rsp_valid[0]=1 with rsp_rdata=0xA at T+3; busy high T+1..T+3.
- req0 and req1 both valid continuously (reads, addr 1 and 3): grants alternate 0,1,0,1. Each accept is 4 cycles apart. rsp_valid goes to the matching requester only.
- Only req1 valid, three writes (addr 0..2, data 0x1..0x3): granted back-to-back every 3 cycles; reads then return 0x1, 0x2, 0x3.
- rst asserted in the ACCESS cycle of a read: next cycle state=IDLE, busy=0, rsp_valid never pulses for it, req_ready=0 while rst=1; a new request is accepted the cycle after rst drops.
- Write 0x5 to addr 3 by req1, then read addr 3 by req0 submitted in the same cycle as the write: req1 wins only if it is next in round-robin order; whichever order is taken, the read returns either the old data (read first) or 0x5 (write first), matching the grant order.
